// File: rtl/fs2_inst_queue.sv
// Fetch-side instruction queue: compacts valid fetch lanes into a circular
// buffer and offers up to DECODE_WIDTH oldest entries to decode in order.
module fs2_inst_queue #(
  parameter int FETCH_WIDTH  = 4,
  parameter int DECODE_WIDTH = 4,
  parameter int DEPTH        = 16,
  parameter int PKT_W        = 96
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush_i,
  input  logic                          fs1Ready_i,
  input  logic [FETCH_WIDTH-1:0]        valid_i,
  input  logic [FETCH_WIDTH*PKT_W-1:0]  pkt_i,
  input  logic [FETCH_WIDTH*2-1:0]      predCounter_i,
  output logic                          stall_o,
  input  logic                          decReady_i,
  output logic [DECODE_WIDTH-1:0]       valid_o,
  output logic [DECODE_WIDTH*PKT_W-1:0] pkt_o,
  output logic [DECODE_WIDTH*2-1:0]     predCounter_o,
  output logic [$clog2(DEPTH):0]        count_o
);

  // Handshakes: a bundle is accepted when fs1Ready_i=1 and stall_o=0; the
  // offered run (valid_o) is consumed in full when decReady_i=1. flush_i
  // overrides both and empties the queue at the next edge.

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = PKT_W + 2;

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [ENT_W-1:0] mem_d [DEPTH];

  logic [CNT_W-1:0] n_avail;
  logic [CNT_W-1:0] n_push;
  logic [CNT_W-1:0] n_pop;
  logic             push_en;
  logic             pop_en;

  // Stall looks at occupancy only, so decReady_i never reaches the fetch path.
  assign stall_o = (CNT_W'(DEPTH) - count_q) < CNT_W'(FETCH_WIDTH);
  assign count_o = count_q;
  assign n_avail = (count_q < CNT_W'(DECODE_WIDTH)) ? count_q : CNT_W'(DECODE_WIDTH);
  assign push_en = fs1Ready_i & ~stall_o & ~flush_i;
  assign pop_en  = decReady_i & ~flush_i;
  assign n_pop   = pop_en ? n_avail : '0;

  always_comb begin : offer
    valid_o       = '0;
    pkt_o         = '0;
    predCounter_o = '0;
    for (int k = 0; k < DECODE_WIDTH; k++) begin
      valid_o[k] = CNT_W'(k) < n_avail;
      {predCounter_o[k*2 +: 2], pkt_o[k*PKT_W +: PKT_W]} = mem_q[head_q + PTR_W'(k)];
    end
  end

  // Valid lanes land in consecutive slots from tail, lowest lane first.
  always_comb begin : compact_write
    mem_d  = mem_q;
    n_push = '0;
    for (int l = 0; l < FETCH_WIDTH; l++) begin
      if (push_en && valid_i[l]) begin
        mem_d[tail_q + n_push[PTR_W-1:0]] = {predCounter_i[l*2 +: 2], pkt_i[l*PKT_W +: PKT_W]};
        n_push = n_push + CNT_W'(1);
      end
    end
  end

  always_comb begin : next_state
    head_d  = head_q + n_pop[PTR_W-1:0];
    tail_d  = tail_q + n_push[PTR_W-1:0];
    count_d = count_q + n_push - n_pop;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  a_count_bound: assert property (@(posedge clk) disable iff (reset)
    count_q <= CNT_W'(DEPTH));

  a_valid_thermo: assert property (@(posedge clk) disable iff (reset)
    (valid_o & DECODE_WIDTH'(valid_o + 1'b1)) == '0);

  a_stall_holds_tail: assert property (@(posedge clk) disable iff (reset)
    (stall_o && !flush_i) |=> (tail_q == $past(tail_q)));

endmodule

// File: tb/tb_fs2_inst_queue.sv
// Bench for fs2_inst_queue: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_fs2_inst_queue;

  localparam int FW    = 4;
  localparam int DW    = 4;
  localparam int DEPTH = 16;
  localparam int PKT_W = 96;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int EW    = PKT_W + 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 flush_i;
  logic                 fs1Ready_i;
  logic [FW-1:0]        valid_i;
  logic [FW*PKT_W-1:0]  pkt_i;
  logic [FW*2-1:0]      predCounter_i;
  logic                 stall_o;
  logic                 decReady_i;
  logic [DW-1:0]        valid_o;
  logic [DW*PKT_W-1:0]  pkt_o;
  logic [DW*2-1:0]      predCounter_o;
  logic [CNT_W-1:0]     count_o;

  logic [EW-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  fs2_inst_queue #(.FETCH_WIDTH(FW), .DECODE_WIDTH(DW), .DEPTH(DEPTH), .PKT_W(PKT_W)) dut (
    .clk(clk), .reset(reset), .flush_i(flush_i), .fs1Ready_i(fs1Ready_i),
    .valid_i(valid_i), .pkt_i(pkt_i), .predCounter_i(predCounter_i),
    .stall_o(stall_o), .decReady_i(decReady_i), .valid_o(valid_o),
    .pkt_o(pkt_o), .predCounter_o(predCounter_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    reset         = 1'b0;
    flush_i       = 1'b0;
    fs1Ready_i    = 1'b0;
    decReady_i    = 1'b0;
    valid_i       = '0;
    pkt_i         = '0;
    predCounter_i = '0;
  endtask

  task automatic set_lane(input int l, input logic [31:0] pc, input logic [1:0] ctr);
    valid_i[l]                = 1'b1;
    pkt_i[l*PKT_W +: PKT_W]   = {$urandom(), $urandom(), pc};
    predCounter_i[l*2 +: 2]   = ctr;
  endtask

  // Reference model: a FIFO of entries; pops take the oldest min(size,DW)
  // entries, pushes append the valid lanes in lane order.
  task automatic step();
    int sz;
    int n_avail;
    bit stall_m;
    sz      = exp_q.size();
    n_avail = (sz < DW) ? sz : DW;
    stall_m = (DEPTH - sz) < FW;
    if (reset || flush_i) begin
      exp_q.delete();
    end else begin
      if (decReady_i) repeat (n_avail) void'(exp_q.pop_front());
      if (fs1Ready_i && !stall_m)
        for (int l = 0; l < FW; l++)
          if (valid_i[l]) exp_q.push_back({predCounter_i[l*2 +: 2], pkt_i[l*PKT_W +: PKT_W]});
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] slot_pc(input int k);
    return pkt_o[k*PKT_W +: 32];
  endfunction

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    total++; if (count_o !== 0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count_o); end
    total++; if (valid_o !== 4'b0000) begin bad++; $display("FAIL reset_valid got=%b exp=0000", valid_o); end
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall_o); end
  endtask

  task automatic test_basic();
    idle_inputs();
    for (int k = 0; k < 4; k++) set_lane(k, 32'h100 + 32'(4*k), 2'(k));
    fs1Ready_i = 1'b1;
    total++; if (valid_o !== 4'b0000) begin bad++; $display("FAIL basic_no_bypass got=%b exp=0000", valid_o); end
    step();
    idle_inputs();
    total++; if (count_o !== 4) begin bad++; $display("FAIL basic_count got=%0d exp=4", count_o); end
    total++; if (valid_o !== 4'b1111) begin bad++; $display("FAIL basic_valid got=%b exp=1111", valid_o); end
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL basic_stall got=%b exp=0", stall_o); end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (slot_pc(k) !== 32'h100 + 32'(4*k)) begin
        bad++; $display("FAIL basic_slot%0d got=%h exp=%h", k, slot_pc(k), 32'h100 + 32'(4*k));
      end
    end
    total++; if (predCounter_o !== 8'b11_10_01_00) begin bad++; $display("FAIL basic_pred got=%b exp=11100100", predCounter_o); end
    decReady_i = 1'b1;
    step();
    idle_inputs();
    total++; if (count_o !== 0) begin bad++; $display("FAIL basic_drain got=%0d exp=0", count_o); end
  endtask

  task automatic test_compaction();
    idle_inputs();
    set_lane(1, 32'h204, 2'd2);
    set_lane(3, 32'h20C, 2'd1);
    pkt_i[0 +: 32]         = 32'h200;
    pkt_i[2*PKT_W +: 32]   = 32'h208;
    fs1Ready_i = 1'b1;
    step();
    idle_inputs();
    total++; if (count_o !== 2) begin bad++; $display("FAIL comp_count got=%0d exp=2", count_o); end
    total++; if (valid_o !== 4'b0011) begin bad++; $display("FAIL comp_valid got=%b exp=0011", valid_o); end
    total++; if (slot_pc(0) !== 32'h204) begin bad++; $display("FAIL comp_slot0 got=%h exp=204", slot_pc(0)); end
    total++; if (slot_pc(1) !== 32'h20C) begin bad++; $display("FAIL comp_slot1 got=%h exp=20c", slot_pc(1)); end
    total++; if (predCounter_o[3:0] !== 4'b01_10) begin bad++; $display("FAIL comp_pred got=%b exp=0110", predCounter_o[3:0]); end
    decReady_i = 1'b1;
    step();
    idle_inputs();
  endtask

  task automatic test_full_stall();
    idle_inputs();
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 4; k++) set_lane(k, 32'h300 + 32'(16*b + 4*k), 2'd0);
      fs1Ready_i = 1'b1;
      step();
    end
    idle_inputs();
    total++; if (count_o !== 16) begin bad++; $display("FAIL full_count got=%0d exp=16", count_o); end
    total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL full_stall got=%b exp=1", stall_o); end
    total++; if (valid_o !== 4'b1111) begin bad++; $display("FAIL full_valid got=%b exp=1111", valid_o); end
    for (int k = 0; k < 4; k++) set_lane(k, 32'h3F0 + 32'(4*k), 2'd3);
    fs1Ready_i = 1'b1;
    step();
    idle_inputs();
    total++; if (count_o !== 16) begin bad++; $display("FAIL held_count got=%0d exp=16", count_o); end
    total++; if (slot_pc(0) !== 32'h300) begin bad++; $display("FAIL held_slot0 got=%h exp=300", slot_pc(0)); end
    decReady_i = 1'b1;
    step();
    idle_inputs();
    total++; if (count_o !== 12) begin bad++; $display("FAIL pop_count got=%0d exp=12", count_o); end
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL pop_stall got=%b exp=0", stall_o); end
    for (int i = 1; i < 4; i++) begin
      total++;
      if (slot_pc(0) !== 32'h300 + 32'(16*i)) begin
        bad++; $display("FAIL full_order%0d got=%h exp=%h", i, slot_pc(0), 32'h300 + 32'(16*i));
      end
      total++;
      if (slot_pc(3) !== 32'h30C + 32'(16*i)) begin
        bad++; $display("FAIL full_tail%0d got=%h exp=%h", i, slot_pc(3), 32'h30C + 32'(16*i));
      end
      decReady_i = 1'b1;
      step();
      idle_inputs();
    end
    total++; if (count_o !== 0) begin bad++; $display("FAIL full_drain got=%0d exp=0", count_o); end
  endtask

  task automatic test_wrap();
    idle_inputs();
    for (int k = 0; k < 4; k++) set_lane(k, 32'h400 + 32'(4*k), 2'd1);
    fs1Ready_i = 1'b1;
    step();
    for (int i = 1; i <= 10; i++) begin
      total++; if (count_o !== 4) begin bad++; $display("FAIL wrap_count%0d got=%0d exp=4", i, count_o); end
      for (int k = 0; k < 4; k++) begin
        total++;
        if (slot_pc(k) !== 32'h400 + 32'(16*(i-1) + 4*k)) begin
          bad++; $display("FAIL wrap_slot c%0d k%0d got=%h exp=%h", i, k, slot_pc(k), 32'h400 + 32'(16*(i-1) + 4*k));
        end
      end
      idle_inputs();
      for (int k = 0; k < 4; k++) set_lane(k, 32'h400 + 32'(16*i + 4*k), 2'd1);
      fs1Ready_i = 1'b1;
      decReady_i = 1'b1;
      step();
    end
    idle_inputs();
    total++; if (slot_pc(0) !== 32'h4A0) begin bad++; $display("FAIL wrap_last got=%h exp=4a0", slot_pc(0)); end
    decReady_i = 1'b1;
    step();
    idle_inputs();
    total++; if (count_o !== 0) begin bad++; $display("FAIL wrap_drain got=%0d exp=0", count_o); end
  endtask

  task automatic test_partial();
    idle_inputs();
    for (int k = 0; k < 3; k++) set_lane(k, 32'h500 + 32'(4*k), 2'd2);
    fs1Ready_i = 1'b1;
    step();
    idle_inputs();
    total++; if (valid_o !== 4'b0111) begin bad++; $display("FAIL part_valid got=%b exp=0111", valid_o); end
    decReady_i = 1'b1;
    step();
    idle_inputs();
    total++; if (count_o !== 0) begin bad++; $display("FAIL part_count got=%0d exp=0", count_o); end
    for (int k = 0; k < 3; k++) set_lane(k, 32'h510 + 32'(4*k), 2'd2);
    fs1Ready_i = 1'b1;
    step();
    idle_inputs();
    set_lane(0, 32'h600, 2'd3);
    set_lane(1, 32'h604, 2'd3);
    fs1Ready_i = 1'b1;
    decReady_i = 1'b1;
    total++; if (valid_o !== 4'b0111) begin bad++; $display("FAIL part_same_valid got=%b exp=0111", valid_o); end
    total++; if (slot_pc(0) !== 32'h510) begin bad++; $display("FAIL part_same_slot0 got=%h exp=510", slot_pc(0)); end
    step();
    idle_inputs();
    total++; if (count_o !== 2) begin bad++; $display("FAIL part_push_count got=%0d exp=2", count_o); end
    total++; if (valid_o !== 4'b0011) begin bad++; $display("FAIL part_push_valid got=%b exp=0011", valid_o); end
    total++; if (slot_pc(0) !== 32'h600) begin bad++; $display("FAIL part_push_slot0 got=%h exp=600", slot_pc(0)); end
    total++; if (slot_pc(1) !== 32'h604) begin bad++; $display("FAIL part_push_slot1 got=%h exp=604", slot_pc(1)); end
    decReady_i = 1'b1;
    step();
    idle_inputs();
  endtask

  task automatic test_flush_reset(input bit use_reset);
    idle_inputs();
    for (int b = 0; b < 3; b++) begin
      for (int k = 0; k < ((b == 2) ? 1 : 4); k++) set_lane(k, 32'h700 + 32'(16*b + 4*k), 2'd0);
      fs1Ready_i = 1'b1;
      step();
      idle_inputs();
    end
    total++; if (count_o !== 9) begin bad++; $display("FAIL fr%0d_setup got=%0d exp=9", use_reset, count_o); end
    for (int k = 0; k < 4; k++) set_lane(k, 32'h7E0 + 32'(4*k), 2'd1);
    fs1Ready_i = 1'b1;
    decReady_i = 1'b1;
    if (use_reset) reset = 1'b1;
    else flush_i = 1'b1;
    step();
    idle_inputs();
    total++; if (count_o !== 0) begin bad++; $display("FAIL fr%0d_count got=%0d exp=0", use_reset, count_o); end
    total++; if (valid_o !== 4'b0000) begin bad++; $display("FAIL fr%0d_valid got=%b exp=0000", use_reset, valid_o); end
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL fr%0d_stall got=%b exp=0", use_reset, stall_o); end
    set_lane(0, 32'h7F0, 2'd2);
    fs1Ready_i = 1'b1;
    step();
    idle_inputs();
    total++; if (count_o !== 1) begin bad++; $display("FAIL fr%0d_push_count got=%0d exp=1", use_reset, count_o); end
    total++; if (valid_o !== 4'b0001) begin bad++; $display("FAIL fr%0d_push_valid got=%b exp=0001", use_reset, valid_o); end
    total++; if (slot_pc(0) !== 32'h7F0) begin bad++; $display("FAIL fr%0d_push_slot0 got=%h exp=7f0", use_reset, slot_pc(0)); end
    decReady_i = 1'b1;
    step();
    idle_inputs();
  endtask

  task automatic test_random();
    int sz;
    int n_av;
    logic [DW-1:0] exp_valid;
    logic [31:0] pc;
    pc = 32'h1000;
    for (int c = 0; c < 800; c++) begin
      sz        = exp_q.size();
      n_av      = (sz < DW) ? sz : DW;
      exp_valid = DW'((1 << n_av) - 1);
      total++; if (count_o !== CNT_W'(sz)) begin bad++; $display("FAIL rnd_count c%0d got=%0d exp=%0d", c, count_o, sz); end
      total++; if (stall_o !== ((DEPTH - sz) < FW)) begin bad++; $display("FAIL rnd_stall c%0d got=%b exp=%b", c, stall_o, (DEPTH - sz) < FW); end
      total++; if (valid_o !== exp_valid) begin bad++; $display("FAIL rnd_valid c%0d got=%b exp=%b", c, valid_o, exp_valid); end
      for (int k = 0; k < n_av; k++) begin
        total++;
        if ({predCounter_o[k*2 +: 2], pkt_o[k*PKT_W +: PKT_W]} !== exp_q[k]) begin
          bad++;
          $display("FAIL rnd_slot c%0d k%0d got=%h exp=%h", c, k,
                   {predCounter_o[k*2 +: 2], pkt_o[k*PKT_W +: PKT_W]}, exp_q[k]);
        end
      end
      idle_inputs();
      flush_i    = ($urandom_range(0, 63) == 0);
      fs1Ready_i = ($urandom_range(0, 3) != 0);
      decReady_i = ($urandom_range(0, 99) < (((c / 100) % 2 == 0) ? 25 : 80));
      for (int l = 0; l < FW; l++) begin
        if ($urandom_range(0, 1) == 1) begin
          set_lane(l, pc, 2'($urandom_range(0, 3)));
          pc = pc + 32'd4;
        end
      end
      step();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    test_reset();
    test_basic();
    test_compaction();
    test_full_stall();
    test_wrap();
    test_partial();
    test_flush_reset(1'b0);
    test_flush_reset(1'b1);
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
